rr_resource_arbiter: RTL and testbench

- Round-robin arbiter and grant sequencer that lets N_REQ requesters share one `simple_example`-style datapath. That datapath has a single (a, b) input pair.
- Registers a one-hot grant and bounds each tenure with MAX_HOLD.
- Steers the owner's a/b bits onto the shared datapath inputs.
- Sits between requester logic and the shared unit. Written to be formally checkable: one-hot grant, fairness and bounded hold.

---
 rtl/rr_resource_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rr_resource_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin arbiter with bounded grant tenure and shared-datapath operand steering
//
// Purpose:
//   Lets N_REQ requesters take turns owning one shared datapath that has a
//   single (a, b) operand pair. Ownership is a registered one-hot grant.
//   A grant ends when the owner drops req, when it flags its final cycle with
//   last, or when MAX_HOLD cycles have gone by. The owner's a/b bits are muxed
//   onto a_out/b_out.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low
//   req      in   [N_REQ]  level-sensitive request per requester
//   last     in   [N_REQ]  final-cycle marker, honoured only for the owner
//   a_in     in   [N_REQ]  operand a per requester
//   b_in     in   [N_REQ]  operand b per requester
//   gnt      out  [N_REQ]  registered one-hot grant, or zero
//   gnt_id   out  [IDW]    owner index, valid while busy
//   busy     out           registered, high while a grant is held
//   a_out    out           a_in[gnt_id] while busy, else 0
//   b_out    out           b_in[gnt_id] while busy, else 0
//   timeout  out           one-cycle pulse after a MAX_HOLD force-release

module rr_resource_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             a_out,
    output logic             b_out,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] ID_MAX    = IDW'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [7:0]       hcnt_q, hcnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             rel_drop;
    logic             rel_last;
    logic             rel_hold;
    logic [IDW-1:0]   ptr_after;
    logic [IDW:0]     win;

    // First set bit of r scanning p, p+1, ..., N_REQ-1, 0, ..., p-1.
    // Result is {found, index}.
    function automatic logic [IDW:0] arbitrate(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   p);
        logic           found;
        logic [IDW-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(p) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        win       = '0;

        rel_drop  = !req[gnt_id_q];
        rel_last  = req[gnt_id_q] && last[gnt_id_q];
        rel_hold  = (hcnt_q == HOLD_LAST);
        ptr_after = (gnt_id_q == ID_MAX) ? '0 : gnt_id_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    win      = arbitrate(req, ptr_q);
                    state_d  = OWN;
                    gnt_d    = onehot(win[IDW-1:0]);
                    gnt_id_d = win[IDW-1:0];
                    busy_d   = 1'b1;
                    hcnt_d   = '0;
                end
            end
            OWN: begin
                if (rel_drop || rel_last || rel_hold) begin
                    // Only a pure MAX_HOLD release is reported; a drop or a
                    // last in the same cycle means the owner finished anyway.
                    timeout_d = rel_hold && !rel_drop && !rel_last;
                    ptr_d     = ptr_after;
                    // The outgoing owner is masked so it cannot win the
                    // handover even if it is still requesting.
                    win       = arbitrate(req & ~onehot(gnt_id_q), ptr_after);
                    hcnt_d    = '0;
                    if (win[IDW]) begin
                        state_d  = OWN;
                        gnt_d    = onehot(win[IDW-1:0]);
                        gnt_id_d = win[IDW-1:0];
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        busy_d   = 1'b0;
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        a_out = 1'b0;
        b_out = 1'b0;
        if (busy_q) begin
            a_out = a_in[gnt_id_q];
            b_out = b_in[gnt_id_q];
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb/tb_rr_resource_arbiter.sv - self-checking bench for rr_resource_arbiter

module tb_rr_resource_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       a_out;
    logic       b_out;
    logic       timeout;

    int checks;
    int passes;

    logic [9:0] sb_q[$];

    rr_resource_arbiter #(
        .N_REQ   (4),
        .MAX_HOLD(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .last   (last),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .a_out  (a_out),
        .b_out  (b_out),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // owner < 0 means no grant held
    function automatic logic [9:0] expv(input int owner, input logic to,
                                        input logic a, input logic b);
        logic [3:0] g;
        logic [1:0] id;
        g  = '0;
        id = '0;
        if (owner >= 0) begin
            g[owner] = 1'b1;
            id       = owner[1:0];
        end
        return {g, id, (owner >= 0), to, a, b};
    endfunction

    function automatic logic [9:0] observe();
        return {gnt, (busy ? gnt_id : 2'b00), busy, timeout, a_out, b_out};
    endfunction

    task automatic apply_reset();
        rst  = 1'b0;
        req  = '0;
        last = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        logic [9:0] o;
        rst  = 1'b0;
        req  = '0;
        last = '0;
        a_in = 4'b1111;
        b_in = 4'b1111;
        #3;
        checks++;
        if ({gnt, gnt_id, busy, timeout, a_out, b_out} !== 10'b0) begin
            $display("FAIL reset_state got %b exp %b", {gnt, gnt_id, busy, timeout, a_out, b_out}, 10'b0);
        end else begin
            passes++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sb_q.push_back(expv(-1, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL idle_no_req cyc %0d got %b exp %b", k, o, e);
            else passes++;
        end
    endtask

    task automatic test_rotation();
        logic [9:0] e;
        logic [9:0] o;
        apply_reset();
        req = 4'b1111;
        for (int k = 1; k <= 40; k++) begin
            sb_q.push_back(expv(((k - 1) / 8) % 4, (k > 1) && ((k - 1) % 8 == 0), 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL rotation cyc %0d got %b exp %b", k, o, e);
            else passes++;
        end
    endtask

    task automatic test_last_and_mux();
        logic [9:0] e;
        logic [9:0] o;
        apply_reset();
        a_in = 4'b0100;
        b_in = 4'b1011;
        for (int k = 1; k <= 7; k++) begin
            req  = (k == 5) ? 4'b0000 : 4'b0100;
            last = (k == 4) ? 4'b0100 : 4'b0000;
            if (k <= 3 || k >= 6) sb_q.push_back(expv(2, 1'b0, 1'b1, 1'b0));
            else                  sb_q.push_back(expv(-1, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL last_release cyc %0d got %b exp %b", k, o, e);
            else passes++;
        end
    endtask

    task automatic test_last_at_limit();
        logic [9:0] e;
        logic [9:0] o;
        apply_reset();
        req = 4'b0011;
        for (int k = 1; k <= 10; k++) begin
            last = (k == 9) ? 4'b0001 : 4'b0000;
            sb_q.push_back(expv((k <= 8) ? 0 : 1, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL last_at_limit cyc %0d got %b exp %b", k, o, e);
            else passes++;
        end
    endtask

    task automatic test_drop();
        logic [9:0] e;
        logic [9:0] o;
        logic [3:0] req_tab [6];
        logic [3:0] last_tab[6];
        int         own_tab [6];
        req_tab  = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0011};
        last_tab = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        own_tab  = '{0, 1, 1, 0, 0, 0};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            req  = req_tab[k];
            last = last_tab[k];
            sb_q.push_back(expv(own_tab[k], 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL drop_handover cyc %0d got %b exp %b", k + 1, o, e);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        logic [9:0] o;
        apply_reset();
        req = 4'b1000;
        for (int k = 1; k <= 6; k++) begin
            sb_q.push_back(expv(3, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL pre_reset_grant cyc %0d got %b exp %b", k, o, e);
            else passes++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, gnt_id, busy, timeout} !== 8'b0) begin
            $display("FAIL async_reset got %b exp %b", {gnt, gnt_id, busy, timeout}, 8'b0);
        end else begin
            passes++;
        end
        req = 4'b1001;
        #2 rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            sb_q.push_back(expv(0, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL post_reset_grant cyc %0d got %b exp %b", k, o, e);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b0;
        req    = '0;
        last   = '0;
        a_in   = '0;
        b_in   = '0;
        test_reset();
        test_rotation();
        test_last_and_mux();
        test_last_at_limit();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
